ex_alu_unit: RTL and testbench
==============================

EX_ALU_UNIT -- requirements
Module: ex_alu_unit

Interface
REQ-001 The port list SHALL be: one clock; reset is synchronous and active-high. Ports: clk, rst (named as the codebase does).
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  operands/opcode valid this cycle.
REQ-005 alu_op  input  3  decode class: 000 ADD-only, 001 BRANCH, 010 R-type, 011 I-type ALU, 100-111 ADD-only.
REQ-006 func3_code  input  3  instruction funct3.
REQ-007 func7_code  input  1  instruction bit 30.
REQ-008 op_A, op_B  input  32 each  operands, already muxed/forwarded upstream.
REQ-009 out_valid  output  1  registered copy of in_valid.
REQ-010 alu_ctrl  output  4  registered decoded operation.
REQ-011 alu_o  output  32  registered result.
REQ-012 br_mark  output  1  registered branch-condition flag.

Function
REQ-013 Decode SHALL be combinational; alu_ctrl codes: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 BEQ, 11 BNE, 12 BLT, 13 BGE, 14 BLTU, 15 BGEU.
REQ-014 R-type func3: 000 -> SUB if func7_code else ADD; 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 -> SRA if func7_code else SRL; 110 OR; 111 AND.
REQ-015 I-type: same as R-type except func3 000 is always ADD (func7_code ignored).
REQ-016 BRANCH func3: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU; 010/011 -> ADD.
REQ-017 alu_op 000 and 100-111 -> ADD regardless of func3/func7_code.
REQ-018 ADD/SUB wrap modulo 2^32; no overflow flag.
REQ-019 Shifts use op_B[4:0] only; SRA replicates op_A[31].
REQ-020 SLT/BLT/BGE signed two's-complement; SLTU/BLTU/BGEU unsigned; SLT/SLTU result zero-extended 0 or 1.
REQ-021 Branch codes: br_mark = condition true; alu_o = {31'b0, br_mark}.
REQ-022 Non-branch codes: br_mark = 0.
REQ-023 Latency exactly 1 cycle: inputs sampled at edge N appear on outputs after edge N; full throughput, no stall.
REQ-024 When in_valid = 0 at an edge: out_valid <= 0; alu_ctrl, alu_o, br_mark hold previous values.

Reset
REQ-025 rst = 1 at an edge SHALL force out_valid, alu_ctrl, alu_o, br_mark to 0, overriding in_valid.
REQ-026 First post-reset result appears the cycle after the first edge with rst = 0 and in_valid = 1; a transaction in flight when rst asserts is discarded.

Configuration
REQ-027 Macro ALU_TRACE_EN defined: each edge with out_valid updated to 1, simulation SHALL print alu_ctrl, op_A, op_B, alu_o in hex.
REQ-028 ALU_TRACE_EN undefined: no print statements compiled; functional behaviour identical.

Verification
REQ-029 R-type, func3 000, func7_code 1, op_A 5, op_B 7 -> next cycle alu_ctrl 1, alu_o FFFFFFFE, br_mark 0.
REQ-030 I-type, func3 000, func7_code 1, op_A 5, op_B 7 -> alu_ctrl 0, alu_o 0000000C.
REQ-031 R-type, func3 101, func7_code 1, op_A 80000000, op_B 00000024 -> alu_ctrl 7, alu_o F8000000 (shift 4).
REQ-032 BRANCH, func3 100, op_A FFFFFFFF, op_B 1 -> br_mark 1, alu_o 1; func3 110 same operands -> br_mark 0, alu_o 0.
REQ-033 Valid transaction then rst = 1 with in_valid = 1 -> all outputs 0 next cycle; in_valid = 0 cycle -> out_valid 0, alu_o held.
REQ-034 Back-to-back ADD 1+1 then SLTU 0<1 on consecutive cycles -> alu_o 2 then 1, out_valid high both cycles.

Source files
------------

// File: rtl/ex_alu_unit.sv
// Execute-stage ALU: combinational decode of alu_op/funct3/funct7 plus a single output register stage.
// Optional `ALU_TRACE_EN` prints each accepted result (alu_ctrl, op_A, op_B, alu_o) in hex.
module ex_alu_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [2:0]  alu_op,
  input  logic [2:0]  func3_code,
  input  logic        func7_code,
  input  logic [31:0] op_A,
  input  logic [31:0] op_B,
  output logic        out_valid,
  output logic [3:0]  alu_ctrl,
  output logic [31:0] alu_o,
  output logic        br_mark
);

  localparam logic [3:0] C_ADD  = 4'd0;
  localparam logic [3:0] C_SUB  = 4'd1;
  localparam logic [3:0] C_SLL  = 4'd2;
  localparam logic [3:0] C_SLT  = 4'd3;
  localparam logic [3:0] C_SLTU = 4'd4;
  localparam logic [3:0] C_XOR  = 4'd5;
  localparam logic [3:0] C_SRL  = 4'd6;
  localparam logic [3:0] C_SRA  = 4'd7;
  localparam logic [3:0] C_OR   = 4'd8;
  localparam logic [3:0] C_AND  = 4'd9;
  localparam logic [3:0] C_BEQ  = 4'd10;
  localparam logic [3:0] C_BNE  = 4'd11;
  localparam logic [3:0] C_BLT  = 4'd12;
  localparam logic [3:0] C_BGE  = 4'd13;
  localparam logic [3:0] C_BLTU = 4'd14;
  localparam logic [3:0] C_BGEU = 4'd15;

  logic [3:0]  ctrl_s;
  logic [31:0] result_s;
  logic        br_s;
  logic [4:0]  shamt_s;
  logic        lt_s;
  logic        ltu_s;

  // R-type and I-type share every funct3 except 000, where only R-type honours funct7
  function automatic logic [3:0] arith_ctrl(input logic [2:0] f3, input logic f7, input logic r_type);
    logic [3:0] c;
    case (f3)
      3'b000:  c = (r_type && f7) ? C_SUB : C_ADD;
      3'b001:  c = C_SLL;
      3'b010:  c = C_SLT;
      3'b011:  c = C_SLTU;
      3'b100:  c = C_XOR;
      3'b101:  c = f7 ? C_SRA : C_SRL;
      3'b110:  c = C_OR;
      3'b111:  c = C_AND;
      default: c = C_ADD;
    endcase
    return c;
  endfunction

  // Decode alu_op / funct3 / funct7 into the 4-bit operation code
  always_comb begin
    ctrl_s = C_ADD;
    case (alu_op)
      3'b001: begin
        case (func3_code)
          3'b000:  ctrl_s = C_BEQ;
          3'b001:  ctrl_s = C_BNE;
          3'b100:  ctrl_s = C_BLT;
          3'b101:  ctrl_s = C_BGE;
          3'b110:  ctrl_s = C_BLTU;
          3'b111:  ctrl_s = C_BGEU;
          default: ctrl_s = C_ADD;
        endcase
      end
      3'b010:  ctrl_s = arith_ctrl(func3_code, func7_code, 1'b1);
      3'b011:  ctrl_s = arith_ctrl(func3_code, func7_code, 1'b0);
      default: ctrl_s = C_ADD;
    endcase
  end

  assign shamt_s = op_B[4:0];
  assign lt_s    = ($signed(op_A) < $signed(op_B));
  assign ltu_s   = (op_A < op_B);

  // Execute the decoded operation; branch codes produce a flag mirrored into bit 0 of the result
  always_comb begin
    result_s = 32'd0;
    br_s     = 1'b0;
    case (ctrl_s)
      C_ADD:   result_s = op_A + op_B;
      C_SUB:   result_s = op_A - op_B;
      C_SLL:   result_s = op_A << shamt_s;
      C_SLT:   result_s = {31'd0, lt_s};
      C_SLTU:  result_s = {31'd0, ltu_s};
      C_XOR:   result_s = op_A ^ op_B;
      C_SRL:   result_s = op_A >> shamt_s;
      C_SRA:   result_s = $unsigned($signed(op_A) >>> shamt_s);
      C_OR:    result_s = op_A | op_B;
      C_AND:   result_s = op_A & op_B;
      C_BEQ:   br_s = (op_A == op_B);
      C_BNE:   br_s = (op_A != op_B);
      C_BLT:   br_s = lt_s;
      C_BGE:   br_s = ~lt_s;
      C_BLTU:  br_s = ltu_s;
      C_BGEU:  br_s = ~ltu_s;
      default: result_s = 32'd0;
    endcase
    if (ctrl_s >= C_BEQ) begin
      result_s = {31'd0, br_s};
    end else begin
      br_s = 1'b0;
    end
  end

  // Output stage: idle cycles drop out_valid but keep the last result visible
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      alu_ctrl  <= 4'd0;
      alu_o     <= 32'd0;
      br_mark   <= 1'b0;
    end else if (in_valid) begin
      out_valid <= 1'b1;
      alu_ctrl  <= ctrl_s;
      alu_o     <= result_s;
      br_mark   <= br_s;
    end else begin
      out_valid <= 1'b0;
    end
  end

`ifdef ALU_TRACE_EN
  // Trace each result as it is captured into the output stage
  always_ff @(posedge clk) begin
    if (!rst && in_valid) begin
      $display("ALU trace: ctrl=%h op_A=%h op_B=%h alu_o=%h", ctrl_s, op_A, op_B, result_s);
    end
  end
`endif

endmodule

// File: tb/tb_ex_alu_unit.sv
// Directed-vector bench for ex_alu_unit with hand-computed expectations.
module tb_ex_alu_unit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [2:0]  alu_op;
  logic [2:0]  func3_code;
  logic        func7_code;
  logic [31:0] op_A;
  logic [31:0] op_B;
  logic        out_valid;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_o;
  logic        br_mark;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  ex_alu_unit dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .alu_op(alu_op),
    .func3_code(func3_code), .func7_code(func7_code), .op_A(op_A), .op_B(op_B),
    .out_valid(out_valid), .alu_ctrl(alu_ctrl), .alu_o(alu_o), .br_mark(br_mark)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present one input set before the edge, then sample just after it.
  task automatic step(input logic r, input logic v, input logic [2:0] op, input logic [2:0] f3,
                      input logic f7, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    rst = r; in_valid = v; alu_op = op; func3_code = f3; func7_code = f7; op_A = a; op_B = b;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_all(input string tag, input logic v, input logic [3:0] c,
                            input logic [31:0] o, input logic b);
    check({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v});
    check({tag, ".ctrl"},  {28'd0, alu_ctrl},  {28'd0, c});
    check({tag, ".alu_o"}, alu_o, o);
    check({tag, ".br"},    {31'd0, br_mark},   {31'd0, b});
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; alu_op = 3'd0; func3_code = 3'd0; func7_code = 1'b0;
    op_A = 32'd0; op_B = 32'd0;

    // reset overrides a valid input
    step(1'b1, 1'b1, 3'b010, 3'b000, 1'b0, 32'd9, 32'd9);
    step(1'b1, 1'b1, 3'b010, 3'b000, 1'b0, 32'd9, 32'd9);
    expect_all("reset", 1'b0, 4'd0, 32'h0, 1'b0);

    step(1'b0, 1'b1, 3'b010, 3'b000, 1'b1, 32'd5, 32'd7);
    expect_all("r_sub", 1'b1, 4'd1, 32'hFFFF_FFFE, 1'b0);
    step(1'b0, 1'b1, 3'b011, 3'b000, 1'b1, 32'd5, 32'd7);
    expect_all("i_add", 1'b1, 4'd0, 32'h0000_000C, 1'b0);
    step(1'b0, 1'b1, 3'b010, 3'b101, 1'b1, 32'h8000_0000, 32'h0000_0024);
    expect_all("r_sra", 1'b1, 4'd7, 32'hF800_0000, 1'b0);
    step(1'b0, 1'b1, 3'b010, 3'b101, 1'b0, 32'h8000_0000, 32'h0000_0024);
    expect_all("r_srl", 1'b1, 4'd6, 32'h0800_0000, 1'b0);
    step(1'b0, 1'b1, 3'b011, 3'b001, 1'b0, 32'd1, 32'd33);
    expect_all("i_sll", 1'b1, 4'd2, 32'd2, 1'b0);
    step(1'b0, 1'b1, 3'b010, 3'b010, 1'b0, 32'hFFFF_FFFF, 32'd1);
    expect_all("slt", 1'b1, 4'd3, 32'd1, 1'b0);
    step(1'b0, 1'b1, 3'b010, 3'b011, 1'b0, 32'hFFFF_FFFF, 32'd1);
    expect_all("sltu", 1'b1, 4'd4, 32'd0, 1'b0);
    step(1'b0, 1'b1, 3'b010, 3'b100, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    expect_all("xor", 1'b1, 4'd5, 32'hFF00_FF00, 1'b0);
    step(1'b0, 1'b1, 3'b010, 3'b110, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    expect_all("or", 1'b1, 4'd8, 32'hFFF0_FFF0, 1'b0);
    step(1'b0, 1'b1, 3'b011, 3'b111, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    expect_all("and", 1'b1, 4'd9, 32'h00F0_00F0, 1'b0);

    step(1'b0, 1'b1, 3'b001, 3'b100, 1'b0, 32'hFFFF_FFFF, 32'd1);
    expect_all("blt", 1'b1, 4'd12, 32'd1, 1'b1);
    step(1'b0, 1'b1, 3'b001, 3'b110, 1'b0, 32'hFFFF_FFFF, 32'd1);
    expect_all("bltu", 1'b1, 4'd14, 32'd0, 1'b0);
    step(1'b0, 1'b1, 3'b001, 3'b101, 1'b0, 32'hFFFF_FFFF, 32'd1);
    expect_all("bge", 1'b1, 4'd13, 32'd0, 1'b0);
    step(1'b0, 1'b1, 3'b001, 3'b111, 1'b0, 32'hFFFF_FFFF, 32'd1);
    expect_all("bgeu", 1'b1, 4'd15, 32'd1, 1'b1);
    step(1'b0, 1'b1, 3'b001, 3'b000, 1'b0, 32'd3, 32'd3);
    expect_all("beq", 1'b1, 4'd10, 32'd1, 1'b1);
    step(1'b0, 1'b1, 3'b001, 3'b001, 1'b0, 32'd3, 32'd3);
    expect_all("bne", 1'b1, 4'd11, 32'd0, 1'b0);
    step(1'b0, 1'b1, 3'b001, 3'b010, 1'b1, 32'd10, 32'd20);
    expect_all("br_f3_010", 1'b1, 4'd0, 32'd30, 1'b0);
    step(1'b0, 1'b1, 3'b101, 3'b101, 1'b1, 32'hFFFF_FFFF, 32'd1);
    expect_all("op101_add_wrap", 1'b1, 4'd0, 32'd0, 1'b0);

    // BEQ true result, then an idle cycle must hold it
    step(1'b0, 1'b1, 3'b001, 3'b000, 1'b0, 32'd7, 32'd7);
    step(1'b0, 1'b0, 3'b010, 3'b000, 1'b1, 32'd5, 32'd7);
    expect_all("idle_hold", 1'b0, 4'd10, 32'd1, 1'b1);

    step(1'b0, 1'b1, 3'b000, 3'b111, 1'b1, 32'd1, 32'd1);
    expect_all("b2b_add", 1'b1, 4'd0, 32'd2, 1'b0);
    step(1'b0, 1'b1, 3'b010, 3'b011, 1'b0, 32'd0, 32'd1);
    expect_all("b2b_sltu", 1'b1, 4'd4, 32'd1, 1'b0);

    // reset with a transaction in flight discards it
    step(1'b0, 1'b1, 3'b010, 3'b000, 1'b0, 32'd100, 32'd23);
    expect_all("pre_rst", 1'b1, 4'd0, 32'd123, 1'b0);
    step(1'b1, 1'b1, 3'b010, 3'b000, 1'b1, 32'd100, 32'd23);
    expect_all("mid_rst", 1'b0, 4'd0, 32'd0, 1'b0);
    step(1'b0, 1'b0, 3'b010, 3'b000, 1'b1, 32'd100, 32'd23);
    expect_all("post_rst_idle", 1'b0, 4'd0, 32'd0, 1'b0);
    step(1'b0, 1'b1, 3'b010, 3'b000, 1'b1, 32'd100, 32'd23);
    expect_all("post_rst_first", 1'b1, 4'd1, 32'd77, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
